// File: rtl/compression_pkg.sv
// Shared sizing helpers for the compression datapath glue blocks.
// Capacity and occupancy width of the elastic pipe register chain.
package compression_pkg;

  localparam int EPR_MAX_DEPTH = 16;

  function automatic int cap_f(input int depth, input int reg_ready);
    return depth * ((reg_ready != 0) ? 2 : 1);
  endfunction

  function automatic int occ_w_f(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid/ready pipeline slot: a main register, plus a skid
// register when the ready path must be fully registered.
module elastic_pipe_stage
  import compression_pkg::*;
#(
  parameter int             W           = 32,
  parameter logic [W-1:0]   RESET_VALUE = '0,
  parameter int             REG_READY   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  if (REG_READY != 0) begin : g_skid
    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] main_d_q, main_d_d;
    logic [W-1:0] skid_d_q, skid_d_d;

    assign in_ready_o  = !skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_d_q;

    // A full skid implies a full main; skid refills main only
    // once main has been consumed, so order is preserved.
    always_comb begin
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      main_d_d = main_d_q;
      skid_d_d = skid_d_q;
      if (flush_i) begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end else if (skid_v_q) begin
        if (out_ready_i) begin
          main_d_d = skid_d_q;
          skid_v_d = 1'b0;
        end
      end else if (in_valid_i) begin
        if (!main_v_q || out_ready_i) begin
          main_v_d = 1'b1;
          main_d_d = in_data_i;
        end else begin
          skid_v_d = 1'b1;
          skid_d_d = in_data_i;
        end
      end else if (out_ready_i) begin
        main_v_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_v_q <= 1'b0;
        skid_v_q <= 1'b0;
        main_d_q <= RESET_VALUE;
        skid_d_q <= RESET_VALUE;
      end else begin
        main_v_q <= main_v_d;
        skid_v_q <= skid_v_d;
        main_d_q <= main_d_d;
        skid_d_q <= skid_d_d;
      end
    end
  end else begin : g_plain
    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;

    assign in_ready_o  = !v_q || out_ready_i;
    assign out_valid_o = v_q;
    assign out_data_o  = d_q;

    always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush_i) begin
        v_d = 1'b0;
      end else if (in_ready_o) begin
        v_d = in_valid_i;
        if (in_valid_i) begin
          d_d = in_data_i;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= RESET_VALUE;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_register.sv
// Stallable DEPTH-stage valid/ready register chain with flush
// and a debug occupancy count.
module elastic_pipe_register
  import compression_pkg::*;
#(
  parameter int                   BIT_WIDTH   = 32,
  parameter int                   DEPTH       = 2,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                   REG_READY   = 1,
  localparam int                  CAP         = cap_f(DEPTH, REG_READY),
  localparam int                  OCC_W       = occ_w_f(CAP)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [BIT_WIDTH-1:0] dataIn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [BIT_WIDTH-1:0] dataOut,
  output logic [OCC_W-1:0]     occupancy
);

  if (DEPTH < 1 || DEPTH > EPR_MAX_DEPTH) begin : g_bad_depth
    $error("elastic_pipe_register: DEPTH out of range 1..16");
  end

  logic             live_q;
  logic             in_v;
  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ_q, occ_d;

  // live_q holds inReady low through reset and releases it one
  // edge later, independent of the stage state.
  assign in_v     = inValid && live_q && !flush;
  assign in_fire  = inValid && inReady;
  assign out_fire = outValid && outReady;

  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    logic                 up_v;
    logic                 dn_r;
    logic [BIT_WIDTH-1:0] up_d;
    logic                 v;
    logic                 r;
    logic [BIT_WIDTH-1:0] d;

    if (i == 0) begin : g_first
      assign up_v = in_v;
      assign up_d = dataIn;
    end else begin : g_mid
      assign up_v = g_st[i-1].v;
      assign up_d = g_st[i-1].d;
    end

    if (i == DEPTH - 1) begin : g_last
      assign dn_r = outReady;
    end else begin : g_inner
      assign dn_r = g_st[i+1].r;
    end

    elastic_pipe_stage #(
      .W           (BIT_WIDTH),
      .RESET_VALUE (RESET_VALUE),
      .REG_READY   (REG_READY)
    ) u_stage (
      .clk         (clk),
      .rst_n       (reset),
      .flush_i     (flush),
      .in_valid_i  (up_v),
      .in_ready_o  (r),
      .in_data_i   (up_d),
      .out_valid_o (v),
      .out_ready_i (dn_r),
      .out_data_o  (d)
    );
  end

  assign inReady   = g_st[0].r && live_q && !flush;
  assign outValid  = g_st[DEPTH-1].v;
  assign dataOut   = g_st[DEPTH-1].d;
  assign occupancy = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      live_q <= 1'b1;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Scoreboard bench: directed vectors on a DEPTH=2 skid chain,
// plus randomized traffic on four extra configurations.
module tb_elastic_pipe_register;

  logic        clk = 1'b0;
  logic        rst_n, flush, inValid, inReady, outValid, outReady;
  logic [31:0] dataIn, dataOut;
  logic [2:0]  occupancy;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        rnd_go = 1'b0;
  logic        rrst_n = 1'b0;

  logic [31:0] exp_q[$];
  int          out_cyc[$];
  int          m_occ = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elastic_pipe_register #(
    .BIT_WIDTH   (32),
    .DEPTH       (2),
    .RESET_VALUE (32'h0),
    .REG_READY   (1)
  ) u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .flush     (flush),
    .inValid   (inValid),
    .inReady   (inReady),
    .dataIn    (dataIn),
    .outValid  (outValid),
    .outReady  (outReady),
    .dataOut   (dataOut),
    .occupancy (occupancy)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, output int acc_cyc);
    int n;
    n = 0;
    inValid = 1'b1;
    dataIn  = x;
    do begin
      @(negedge clk);
      n++;
    end while (!inReady && n < 50);
    chk("send_accept", inReady, 1'b1);
    if (inReady) exp_q.push_back(x);
    acc_cyc = cyc;
    tick();
    inValid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // Output-side monitor and occupancy model for the main DUT
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_occ = 0;
      prev_stall = 1'b0;
    end else begin
      chk("occupancy", occupancy, m_occ);
      if (prev_stall) begin
        chk("hold_valid", outValid, 1'b1);
        chk("hold_data", dataOut, prev_data);
      end
      if (outValid && outReady) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected none", dataOut);
        end else begin
          n_chk--;
          chk("out_data", dataOut, exp_q.pop_front());
        end
        out_cyc.push_back(cyc);
        m_occ--;
      end
      if (inValid && inReady) m_occ++;
      if (flush) begin
        exp_q.delete();
        m_occ = 0;
      end
      prev_stall = outValid && !outReady && !flush;
      prev_data  = dataOut;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int D  = (g < 2) ? 1 : 5;
    localparam int R  = g % 2;
    localparam int OW = $clog2(D * (1 + R) + 1);

    logic          iv = 1'b0, ir, ov, orr = 1'b0, fl = 1'b0, acc;
    logic [31:0]   di = 32'h1000 * (g + 1), dout;
    logic [OW-1:0] oc;
    logic [31:0]   q[$];
    int            mo = 0;
    logic          ps = 1'b0;
    logic [31:0]   pd = '0;

    elastic_pipe_register #(
      .BIT_WIDTH   (32),
      .DEPTH       (D),
      .RESET_VALUE (32'hC0DE_0000),
      .REG_READY   (R)
    ) u_r (
      .clk       (clk),
      .reset     (rrst_n),
      .flush     (fl),
      .inValid   (iv),
      .inReady   (ir),
      .dataIn    (di),
      .outValid  (ov),
      .outReady  (orr),
      .dataOut   (dout),
      .occupancy (oc)
    );

    initial begin
      wait (rnd_go);
      while (rnd_go) begin
        @(negedge clk);
        acc = iv && ir;
        if (acc) q.push_back(di);
        @(posedge clk);
        #1;
        if (acc) di = di + 32'd1;
        if (acc || !iv) iv = ($urandom_range(0, 3) != 0);
        orr = ($urandom_range(0, 3) != 0);
        fl  = ($urandom_range(0, 99) == 0);
      end
      iv  = 1'b0;
      fl  = 1'b0;
      orr = 1'b1;
    end

    always @(negedge clk) begin
      if (!rrst_n) begin
        q.delete();
        mo = 0;
        ps = 1'b0;
      end else begin
        chk($sformatf("r%0d_occ", g), oc, mo);
        if (ps) begin
          chk($sformatf("r%0d_hold_v", g), ov, 1'b1);
          chk($sformatf("r%0d_hold_d", g), dout, pd);
        end
        if (ov && orr) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL r%0d_data: got %0h expected none", g, dout);
          end else begin
            chk($sformatf("r%0d_data", g), dout, q.pop_front());
          end
          mo--;
        end
        if (iv && ir) mo++;
        if (fl) begin
          q.delete();
          mo = 0;
        end
        ps = ov && !orr && !fl;
        pd = dout;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a, cnt, n;
    rst_n    = 1'b0;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    dataIn   = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dataOut", dataOut, 32'h0);
    chk("rst_outValid", outValid, 1'b0);
    chk("rst_inReady", inReady, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rel_inReady", inReady, 1'b1);
    chk("rel_occ", occupancy, 3'd0);
    tick();

    // stream 1..8, no stall
    outReady = 1'b1;
    out_cyc.delete();
    send(32'h1, a0);
    for (int k = 2; k <= 8; k++) send(32'(k), a);
    drain("drain_stream");
    chk("stream_count", out_cyc.size(), 8);
    if (out_cyc.size() == 8) begin
      chk("stream_latency", out_cyc[0] - a0, 2);
      chk("stream_bubbles", out_cyc[7] - out_cyc[0], 7);
    end
    tick();

    // fill until full
    outReady = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      inValid = 1'b1;
      dataIn  = 32'h10 + 32'(k);
      @(negedge clk);
      if (!inReady) break;
      exp_q.push_back(dataIn);
      cnt++;
      tick();
    end
    tick();
    inValid = 1'b0;
    chk("fill_count", cnt, 4);
    chk("fill_occ", occupancy, 3'd4);
    chk("fill_inReady", inReady, 1'b0);
    outReady = 1'b1;
    drain("drain_full");
    @(negedge clk);
    chk("unfull_inReady", inReady, 1'b1);
    tick();

    // flush at occupancy 3 with an output transfer in the same cycle
    outReady = 1'b0;
    send(32'h21, a);
    send(32'h22, a);
    send(32'h23, a);
    flush    = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    chk("flush_occ_before", occupancy, 3'd3);
    chk("flush_inReady", inReady, 1'b0);
    chk("flush_out_v", outValid, 1'b1);
    chk("flush_out_d", dataOut, 32'h21);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_v", outValid, 1'b0);
    chk("post_flush_occ", occupancy, 3'd0);
    tick();
    flush   = 1'b1;
    inValid = 1'b1;
    dataIn  = 32'h99;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_hold_occ", occupancy, 3'd0);
      chk("flush_hold_v", outValid, 1'b0);
      tick();
    end
    flush   = 1'b0;
    inValid = 1'b0;
    tick();

    // async reset mid-stream at occupancy 3
    outReady = 1'b0;
    send(32'h31, a);
    send(32'h32, a);
    send(32'h33, a);
    chk("pre_rst_occ", occupancy, 3'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_outValid", outValid, 1'b0);
    chk("arst_dataOut", dataOut, 32'h0);
    chk("arst_occ", occupancy, 3'd0);
    chk("arst_inReady", inReady, 1'b0);
    repeat (2) tick();
    rst_n    = 1'b1;
    outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale", outValid, 1'b0);
      tick();
    end
    send(32'h40, a);
    drain("drain_after_rst");

    // randomized traffic on the other configurations
    tick();
    rrst_n = 1'b1;
    rnd_go = 1'b1;
    n = 0;
    while (n < 10000) begin
      @(posedge clk);
      n++;
    end
    #1;
    rnd_go = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
